fx_round_pipe: RTL and testbench
================================

Name: fx_round_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational ceil unit for signed fixed-point Q(WI).(WF) data.
- Rounds each sample to an integer-valued fixed-point result in one of four run-time modes: floor, ceil, round-half-up or truncate-toward-zero.
- Flags overflow, wrapping the result by default or saturating it under a build macro, and counts overflow events.
- Sits between fixed-point datapath stages on a valid/ready stream, accepting one sample per cycle.

Parameters:
- WI, 8, integer bits including sign.
- WF, 32, fractional bits.
- CNTW, 16, width of the overflow event counter.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- A  input  WI+WF  signed input sample; integer part is A[WI+WF-1:WF], fraction is A[WF-1:0].
- mode  input  2  rounding mode, sampled together with A. 00 floor, 01 ceil, 10 round-half-up, 11 truncate-toward-zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- rout  output  WI+WF  signed result; fraction bits are always zero.
- oflag  output  1  overflow for this result, qualified by out_valid.
- ovf_count  output  CNTW  number of overflowed results delivered, saturating.

Behaviour:
- Reset: one clock, synchronous, active-high (rst). out_valid=0, rout=0, oflag=0, ovf_count=0, all pipeline valids=0. Reset mid-operation discards all in-flight samples. in_ready=1 in the first cycle after reset.
- Transfers: an input transfer occurs on in_valid&&in_ready; an output transfer occurs on out_valid&&out_ready.
- Pipeline: two register stages, S1 and S2. Latency is 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 sample per cycle.
- Stage enables: en2 = !s2_valid || out_ready; en1 = !s1_valid || en2; in_ready = en1. in_ready depends only on state and out_ready, never on in_valid.
- S1 registers: Int, a nonzero-fraction flag (fnz = |Frac), the fraction MSB (fh = Frac[WF-1]), mode, and valid.
- Increment decision inc, computed in S1:
  - floor: inc=0.
  - ceil: inc=fnz.
  - round-half-up: inc=fh.
  - truncate-toward-zero: inc = fnz && Int[WI-1].
- S2 computes sum = Int + inc in WI+1 bits.
  - Overflow when inc=1 and Int = 2^(WI-1)-1, i.e. the maximum positive integer.
  - No overflow is possible for floor, or for truncate with negative input.
- Result without overflow: rout = {sum[WI-1:0], WF zeros}, oflag=0.
- Result with overflow: behaviour is set by SATURATE_EN (see Optional Feature); oflag=1 in both builds.
- Stall: while out_valid && !out_ready, rout, oflag and out_valid hold stable. S1 holds if S2 is stalled and full.
- ovf_count: increments by 1 on each output transfer with oflag=1. It saturates at 2^CNTW-1 and never wraps.
- Simultaneous events: input and output transfers in the same cycle are legal and lose no data. rst has priority over all transfers.
- Exact-integer inputs (Frac=0) pass unchanged in every mode.

Optional Feature:
- Macro: FX_ROUND_SATURATE_EN.
- Defined: on overflow, rout = {0, (WI-1) ones, WF zeros}, the largest representable integer.
- Undefined: on overflow, rout wraps to {1, (WI-1) zeros, WF zeros}, the most negative integer. This matches the legacy ceil unit.
- oflag and ovf_count behave identically in both builds.

Test Plan:
All values use WI=4, WF=4, CNTW=4.
- A=0x25 (2.3125), modes 00/01/10/11 -> rout=0x20/0x30/0x20/0x20, oflag=0, each out_valid exactly 2 cycles after its input transfer.
- A=0xD8 (-2.5), modes 00/01/10/11 -> rout=0xD0/0xE0/0xE0/0xE0; A=0x30 in any mode -> 0x30.
- A=0x71 with ceil, and A=0x78 with round -> oflag=1. Default build gives rout=0x80; FX_ROUND_SATURATE_EN build gives rout=0x70. ovf_count increments to 1, then 2.
- Back-to-back stream of 8 samples with out_ready toggled randomly -> all 8 results in order, rout held stable during stalls, in_ready=0 only while both stages are full and out_ready=0.
- 17 consecutive overflowing samples -> ovf_count=0xF and held there.
- rst asserted for 1 cycle with 2 samples in flight -> out_valid=0 and ovf_count=0 the next cycle, no stale result emitted, in_ready=1.

Source files
------------

// File: rtl/fx_round_pipe.sv
// Signed Q(WI).(WF) rounder (floor/ceil/half-up/trunc) with overflow flag and saturating event count; FX_ROUND_SATURATE_EN clamps instead of wrapping.
// Latency: 2 cycles from input transfer to out_valid, one sample per cycle.
// Backpressure: valid/ready skid-free pipeline; in_ready = !s1_valid || !s2_valid || out_ready.
module fx_round_pipe #(
    parameter int WI   = 8,
    parameter int WF   = 32,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WI+WF-1:0]   A,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WI+WF-1:0]   rout,
    output logic               oflag,
    output logic [CNTW-1:0]    ovf_count
);
    localparam int W = WI + WF;
    localparam logic [WI-1:0]   INT_MAX = {1'b0, {(WI-1){1'b1}}};
    localparam logic [WI-1:0]   INT_MIN = {1'b1, {(WI-1){1'b0}}};
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic          s1_valid;
    logic [WI-1:0] s1_int;
    logic          s1_fnz;
    logic          s1_fh;
    logic [1:0]    s1_mode;

    logic          s2_valid;
    logic [W-1:0]  s2_rout;
    logic          s2_oflag;

    logic          en1, en2;
    logic          inc;
    logic          ovf;
    logic [WI:0]   sum;
    logic [WI-1:0] res_int;

    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    always_comb begin
        inc = 1'b0;
        case (s1_mode)
            2'b00:   inc = 1'b0;
            2'b01:   inc = s1_fnz;
            2'b10:   inc = s1_fh;
            default: inc = s1_fnz && s1_int[WI-1];
        endcase
    end

    // Only the max positive integer can carry out of range; negatives never overflow upward.
    assign sum = {s1_int[WI-1], s1_int} + {{WI{1'b0}}, inc};
    assign ovf = inc && (s1_int == INT_MAX);

    always_comb begin
        res_int = sum[WI-1:0];
        if (ovf) begin
`ifdef FX_ROUND_SATURATE_EN
            res_int = INT_MAX;
`else
            res_int = INT_MIN;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_int    <= '0;
            s1_fnz    <= 1'b0;
            s1_fh     <= 1'b0;
            s1_mode   <= 2'b00;
            s2_valid  <= 1'b0;
            s2_rout   <= '0;
            s2_oflag  <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                s1_int   <= A[W-1:WF];
                s1_fnz   <= |A[WF-1:0];
                s1_fh    <= A[WF-1];
                s1_mode  <= mode;
            end
            if (en2) begin
                s2_valid <= s1_valid;
                s2_rout  <= {res_int, {WF{1'b0}}};
                s2_oflag <= s1_valid && ovf;
            end
            if (s2_valid && out_ready && s2_oflag && (ovf_count != CNT_MAX))
                ovf_count <= ovf_count + CNT_ONE;
        end
    end

    assign out_valid = s2_valid;
    assign rout      = s2_rout;
    assign oflag     = s2_oflag;
endmodule

// File: tb/tb_fx_round_pipe.sv
// Bench for fx_round_pipe at WI=4, WF=4, CNTW=4: directed vector table, streams against a reference model, reset and counter saturation.
`timescale 1ns/1ps
module tb_fx_round_pipe;
    localparam int WI = 4, WF = 4, CNTW = 4, W = WI + WF;
`ifdef FX_ROUND_SATURATE_EN
    localparam logic [W-1:0] OVF_ROUT = 8'h70;
`else
    localparam logic [W-1:0] OVF_ROUT = 8'h80;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    A = '0;
    logic [1:0]      mode = 2'b00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    rout;
    logic            oflag;
    logic [CNTW-1:0] ovf_count;

    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    fx_round_pipe #(.WI(WI), .WF(WF), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .rout(rout), .oflag(oflag), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: real-valued rounding done with integer arithmetic on the scaled value.
    function automatic void model(input logic [W-1:0] a, input logic [1:0] m,
                                  output logic [W-1:0] r, output logic o);
        int v, q;
        v = int'($signed(a));
        case (m)
            2'd0:    q = v >>> WF;
            2'd1:    q = -((-v) >>> WF);
            2'd2:    q = (v + (1 << (WF - 1))) >>> WF;
            default: q = (v < 0) ? -((-v) >>> WF) : (v >>> WF);
        endcase
        o = (q > ((1 << (WI - 1)) - 1));
        r = o ? OVF_ROUT : W'(q * (1 << WF));
    endfunction

    function automatic void bump_cnt();
        if (exp_cnt < (1 << CNTW) - 1) exp_cnt++;
    endfunction

    typedef struct {
        logic [W-1:0] a;
        logic [1:0]   m;
        logic [W-1:0] r;
        logic         o;
    } vec_t;
    vec_t tbl[14];

    task automatic send_one(input int idx);
        @(posedge clk); #1;
        in_valid = 1'b1; A = tbl[idx].a; mode = tbl[idx].m; out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_lat1_out_valid", idx), out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_lat2_out_valid", idx), out_valid, 1);
        check($sformatf("v%0d_rout", idx), rout, tbl[idx].r);
        check($sformatf("v%0d_oflag", idx), oflag, tbl[idx].o);
        if (tbl[idx].o) bump_cnt();
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_ovf_count", idx), ovf_count, exp_cnt);
    endtask

    // kind 0: back-to-back random samples, random out_ready
    // kind 1: random in_valid gaps, random out_ready
    // kind 2: back-to-back overflowing samples, out_ready held high
    task automatic run_stream(input int n, input int kind, input string tag);
        logic [W-1:0] qr[$];
        logic         qo[$];
        int sent = 0, got = 0, infl = 0, cyc = 0;
        logic held_v = 1'b0, held_o = 1'b0, ivx = 1'b0, ovx, eo;
        logic [W-1:0] held_r = '0, er;
        while (got < n && cyc < 3000) begin
            @(posedge clk); #1;
            if (!in_valid || ivx) begin
                if (sent < n && (kind != 1 || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    if (kind == 2) begin A = 8'h71; mode = 2'b01; end
                    else begin A = W'($urandom); mode = 2'($urandom); end
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held_v) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_rout"}, rout, held_r);
                check({tag, "_stall_oflag"}, oflag, held_o);
            end
            check({tag, "_in_ready"}, in_ready, !(infl == 2 && !out_ready));
            check({tag, "_ovf_count"}, ovf_count, exp_cnt);
            ivx = in_valid && in_ready;
            ovx = out_valid && out_ready;
            if (out_valid && qr.size() == 0) begin
                check({tag, "_spurious_out"}, out_valid, 0);
            end else if (out_valid) begin
                check($sformatf("%s_rout_%0d", tag, got), rout, qr[0]);
                check($sformatf("%s_oflag_%0d", tag, got), oflag, qo[0]);
            end
            held_v = out_valid && !out_ready;
            held_r = rout;
            held_o = oflag;
            if (ivx) begin
                model(A, mode, er, eo);
                qr.push_back(er);
                qo.push_back(eo);
                sent++;
                infl++;
            end
            if (ovx) begin
                if (qo.size() > 0) begin
                    if (qo[0]) bump_cnt();
                    void'(qr.pop_front());
                    void'(qo.pop_front());
                end
                got++;
                infl--;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_received"}, got, n);
        check({tag, "_final_ovf_count"}, ovf_count, exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        tbl[0]  = '{8'h25, 2'b00, 8'h20, 1'b0};
        tbl[1]  = '{8'h25, 2'b01, 8'h30, 1'b0};
        tbl[2]  = '{8'h25, 2'b10, 8'h20, 1'b0};
        tbl[3]  = '{8'h25, 2'b11, 8'h20, 1'b0};
        tbl[4]  = '{8'hD8, 2'b00, 8'hD0, 1'b0};
        tbl[5]  = '{8'hD8, 2'b01, 8'hE0, 1'b0};
        tbl[6]  = '{8'hD8, 2'b10, 8'hE0, 1'b0};
        tbl[7]  = '{8'hD8, 2'b11, 8'hE0, 1'b0};
        tbl[8]  = '{8'h30, 2'b00, 8'h30, 1'b0};
        tbl[9]  = '{8'h30, 2'b01, 8'h30, 1'b0};
        tbl[10] = '{8'h30, 2'b10, 8'h30, 1'b0};
        tbl[11] = '{8'h30, 2'b11, 8'h30, 1'b0};
        tbl[12] = '{8'h71, 2'b01, OVF_ROUT, 1'b1};
        tbl[13] = '{8'h78, 2'b10, OVF_ROUT, 1'b1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_rout", rout, 0);
        check("rst_oflag", oflag, 0);
        check("rst_ovf_count", ovf_count, 0);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) send_one(i);

        run_stream(8, 0, "burst8");
        run_stream(200, 1, "rand");

        // Two samples in flight with downstream stalled, then reset.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; A = 8'h71; mode = 2'b01;
        @(posedge clk); #1;
        A = 8'h78; mode = 2'b10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_ovf_count", ovf_count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("mid_rst_stale_results", stale, 0);

        run_stream(17, 2, "ovf17");
        check("ovf_count_saturated", ovf_count, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovf_count_held", ovf_count, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
